spi_master_z: RTL and testbench

SPI mode-0 master (CPOL=0, CPHA=0) that drives the recording chip's slave port (CS_b/SCLK/MOSI) and captures MISO. It runs in the controller/test-harness FPGA fabric, and converts one parallel frame request into one CS-framed serial transfer, MSB first. Full-duplex: each transfer returns FRAME_BITS bits read back from MISO.

---
 rtl/spi_z_pkg.sv | 23 ++
 rtl/spi_sclk_gen.sv | 77 +++++++
 rtl/spi_master_z.sv | 124 ++++++++++++
 tb/tb_spi_master_z.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_z_pkg.sv
// Shared types and default constants for the spi_master_z SPI mode-0 master.
package spi_z_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD,
        S_SHIFT_HI,
        S_SHIFT_LO,
        S_GAP
    } spi_state_e;

    localparam int SPI_FRAME_BITS = 32;
    localparam int SPI_DIV        = 2;
    localparam int SPI_LEAD       = 2;
    localparam int SPI_GAP        = 4;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// Phase timer and SCLK register; tells the FSM when the current phase ends.
module spi_sclk_gen
    import spi_z_pkg::*;
#(
    parameter int DIV  = SPI_DIV,
    parameter int LEAD = SPI_LEAD,
    parameter int GAP  = SPI_GAP
) (
    input  logic       clk,
    input  logic       rst,
    input  spi_state_e state_i,
    input  logic       last_bit_i,
    output logic       sclk_o,
    output logic       rise_next_o,
    output logic       fall_next_o,
    output logic       phase_end_o
);

    localparam int PMAX = max3(DIV, LEAD, GAP);
    localparam int PW   = $clog2(PMAX + 1);

    logic [PW-1:0] cnt_q;
    logic [PW-1:0] cnt_d;
    logic [PW-1:0] len_m1;
    logic          sclk_q;
    logic          sclk_d;
    logic          phase_end;

    always_comb begin
        len_m1 = '0;
        unique case (state_i)
            S_LEAD:     len_m1 = PW'(LEAD - 1);
            S_SHIFT_HI: len_m1 = PW'(DIV - 1);
            S_SHIFT_LO: len_m1 = PW'(DIV - 1);
            S_GAP:      len_m1 = PW'(GAP - 1);
            default:    len_m1 = '0;
        endcase
    end

    assign phase_end = (state_i != S_IDLE) && (cnt_q == len_m1);

    // The last low phase ends the frame instead of raising SCLK again.
    assign rise_next_o = phase_end &&
                         ((state_i == S_LEAD) ||
                          ((state_i == S_SHIFT_LO) && !last_bit_i));
    assign fall_next_o = phase_end && (state_i == S_SHIFT_HI);
    assign phase_end_o = phase_end;

    always_comb begin
        cnt_d = cnt_q + PW'(1);
        if ((state_i == S_IDLE) || phase_end) begin
            cnt_d = '0;
        end
    end

    always_comb begin
        sclk_d = sclk_q;
        if (rise_next_o) begin
            sclk_d = 1'b1;
        end else if (fall_next_o) begin
            sclk_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

    assign sclk_o = sclk_q;

endmodule

// File: rtl/spi_master_z.sv
// SPI mode-0 master: one parallel request becomes one CS-framed, MSB-first,
// full-duplex transfer; MISO bits are returned in rx_data.
module spi_master_z
    import spi_z_pkg::*;
#(
    parameter int FRAME_BITS = SPI_FRAME_BITS,
    parameter int DIV        = SPI_DIV,
    parameter int LEAD       = SPI_LEAD,
    parameter int GAP        = SPI_GAP
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [FRAME_BITS-1:0] tx_data,
    output logic                  ready,
    output logic [FRAME_BITS-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  CS_b,
    output logic                  SCLK,
    output logic                  MOSI,
    input  logic                  MISO
);

    localparam int BW = $clog2(FRAME_BITS + 1);

    spi_state_e            state_q;
    logic [BW-1:0]         bit_cnt_q;
    logic [FRAME_BITS-1:0] tx_sh_q;
    logic [FRAME_BITS-1:0] rx_sh_q;
    logic [FRAME_BITS-1:0] rx_data_q;
    logic                  rx_valid_q;
    logic                  cs_b_q;
    logic                  ready_q;

    logic last_bit;
    logic rise_next;
    logic fall_next;
    logic phase_end;

    assign last_bit = (bit_cnt_q == BW'(FRAME_BITS - 1));

    spi_sclk_gen #(
        .DIV  (DIV),
        .LEAD (LEAD),
        .GAP  (GAP)
    ) u_sclk (
        .clk         (clk),
        .rst         (rst),
        .state_i     (state_q),
        .last_bit_i  (last_bit),
        .sclk_o      (SCLK),
        .rise_next_o (rise_next),
        .fall_next_o (fall_next),
        .phase_end_o (phase_end)
    );

    // MOSI is the MSB of the tx shifter, so clearing it also idles MOSI low.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            bit_cnt_q  <= '0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            cs_b_q     <= 1'b1;
            ready_q    <= 1'b1;
        end else begin
            rx_valid_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        tx_sh_q   <= tx_data;
                        rx_sh_q   <= '0;
                        bit_cnt_q <= '0;
                        cs_b_q    <= 1'b0;
                        ready_q   <= 1'b0;
                        state_q   <= S_LEAD;
                    end
                end
                S_LEAD: begin
                    if (rise_next) begin
                        state_q <= S_SHIFT_HI;
                    end
                end
                S_SHIFT_HI: begin
                    if (fall_next) begin
                        rx_sh_q <= {rx_sh_q[FRAME_BITS-2:0], MISO};
                        state_q <= S_SHIFT_LO;
                    end
                end
                S_SHIFT_LO: begin
                    if (rise_next) begin
                        bit_cnt_q <= bit_cnt_q + BW'(1);
                        tx_sh_q   <= tx_sh_q << 1;
                        state_q   <= S_SHIFT_HI;
                    end else if (phase_end) begin
                        tx_sh_q    <= '0;
                        cs_b_q     <= 1'b1;
                        rx_data_q  <= rx_sh_q;
                        rx_valid_q <= 1'b1;
                        state_q    <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (phase_end) begin
                        ready_q <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ready    = ready_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign CS_b     = cs_b_q;
    assign MOSI     = tx_sh_q[FRAME_BITS-1];

endmodule

// File: tb/tb_spi_master_z.sv
// Randomized bench for spi_master_z: two instances (default and tight timing)
// compared every cycle against a frame-offset model, plus literal scenarios.
module tb_spi_master_z;

    localparam int F  = 32;
    localparam int NI = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [NI-1:0]        rst;
    logic [NI-1:0]        start;
    logic [NI-1:0]        miso;
    logic [NI-1:0]        ready;
    logic [NI-1:0]        rxv;
    logic [NI-1:0]        cs;
    logic [NI-1:0]        sclk;
    logic [NI-1:0]        mosi;
    logic [NI-1:0][F-1:0] tx;
    logic [NI-1:0][F-1:0] rxd;

    logic        slv_mode = 1'b0;
    logic        slv_bit  = 1'b0;
    logic [31:0] slv_word = 32'h12345678;
    int          sidx     = 0;

    assign miso[0] = slv_mode ? slv_bit : mosi[0];
    assign miso[1] = mosi[1];

    spi_master_z #(
        .FRAME_BITS (F), .DIV (2), .LEAD (2), .GAP (4)
    ) u_dut0 (
        .clk      (clk),
        .rst      (rst[0]),
        .start    (start[0]),
        .tx_data  (tx[0]),
        .ready    (ready[0]),
        .rx_data  (rxd[0]),
        .rx_valid (rxv[0]),
        .CS_b     (cs[0]),
        .SCLK     (sclk[0]),
        .MOSI     (mosi[0]),
        .MISO     (miso[0])
    );

    spi_master_z #(
        .FRAME_BITS (F), .DIV (1), .LEAD (1), .GAP (1)
    ) u_dut1 (
        .clk      (clk),
        .rst      (rst[1]),
        .start    (start[1]),
        .tx_data  (tx[1]),
        .ready    (ready[1]),
        .rx_data  (rxd[1]),
        .rx_valid (rxv[1]),
        .CS_b     (cs[1]),
        .SCLK     (sclk[1]),
        .MOSI     (mosi[1]),
        .MISO     (miso[1])
    );

    function automatic int p_div(input int i);
        return (i == 0) ? 2 : 1;
    endfunction
    function automatic int p_lead(input int i);
        return (i == 0) ? 2 : 1;
    endfunction
    function automatic int p_gap(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    int errors = 0;
    int checks = 0;

    // Model: each frame is described only by edges elapsed since acceptance.
    bit         busy  [NI];
    int         off   [NI];
    logic [F-1:0] txm [NI];
    logic [F-1:0] rxe [NI];
    logic [F-1:0] rxd_e [NI];

    logic       prev_sclk [NI];
    logic       prev_cs   [NI];
    int         rises     [NI];
    int         fr_rises  [NI];
    int         cs_low    [NI];
    int         rxv_cnt   [NI];
    int         mosi_ones [NI];
    int         hi_run    [NI];
    logic [F-1:0] mosi_cap [NI];
    bit         seen1 = 1'b0;
    int         gap_q  [$];
    int         rise_q [$];
    logic [F-1:0] rx1_q [$];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h",
                     nm, $time, act, exp);
        end
    endtask

    function automatic logic [F+4:0] expect_out(input int i);
        int   d, l, t, bi;
        logic e_cs, e_sclk, e_mosi, e_rdy, e_rxv;
        d = p_div(i);
        l = p_lead(i);
        t = l + 2 * d * F;
        e_cs = 1'b1; e_sclk = 1'b0; e_mosi = 1'b0;
        e_rdy = 1'b1; e_rxv = 1'b0;
        if (busy[i]) begin
            e_rdy = 1'b0;
            if (off[i] < t) begin
                e_cs   = 1'b0;
                e_sclk = (off[i] >= l) && (((off[i] - l) % (2 * d)) < d);
                bi     = (off[i] < l) ? 0 : (off[i] - l) / (2 * d);
                e_mosi = txm[i][F-1-bi];
            end else if (off[i] == t) begin
                e_rxv = 1'b1;
            end
        end
        return {e_cs, e_sclk, e_mosi, e_rdy, e_rxv, rxd_e[i]};
    endfunction

    task automatic advance(input int i);
        int t;
        t = p_lead(i) + 2 * p_div(i) * F;
        if (rst[i]) begin
            busy[i]  = 1'b0;
            off[i]   = 0;
            rxd_e[i] = '0;
        end else if (!busy[i]) begin
            if (start[i]) begin
                busy[i] = 1'b1;
                off[i]  = 0;
                txm[i]  = tx[i];
                rxe[i]  = (i == 0 && slv_mode) ? slv_word : tx[i];
            end
        end else begin
            off[i]++;
            if (off[i] == t) rxd_e[i] = rxe[i];
            if (off[i] == t + p_gap(i)) busy[i] = 1'b0;
        end
    endtask

    task automatic monitor(input int i);
        if (!prev_sclk[i] && sclk[i]) begin
            rises[i]++;
            fr_rises[i]++;
            mosi_cap[i] = {mosi_cap[i][F-2:0], mosi[i]};
        end
        if (!cs[i]) cs_low[i]++;
        if (mosi[i]) mosi_ones[i]++;
        if (rxv[i]) begin
            rxv_cnt[i]++;
            if (i == 1) rx1_q.push_back(rxd[i]);
        end
        if (prev_cs[i] && !cs[i]) begin
            if (i == 1 && seen1) gap_q.push_back(hi_run[i]);
            fr_rises[i] = 0;
        end
        if (!prev_cs[i] && cs[i]) begin
            hi_run[i] = 1;
            if (i == 1) begin
                rise_q.push_back(fr_rises[i]);
                seen1 = 1'b1;
            end
        end else if (cs[i]) begin
            hi_run[i]++;
        end
        prev_sclk[i] = sclk[i];
        prev_cs[i]   = cs[i];
    endtask

    task automatic tick();
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk((i == 0) ? "cycle_dut0" : "cycle_dut1",
                64'({cs[i], sclk[i], mosi[i], ready[i], rxv[i], rxd[i]}),
                64'(expect_out(i)));
        end
        // Slave presents the next bit just after each SCLK fall.
        if (cs[0]) sidx = 0;
        else if (prev_sclk[0] && !sclk[0]) sidx++;
        slv_bit = (sidx < 32) ? slv_word[31-sidx] : 1'b0;
        for (int i = 0; i < NI; i++) monitor(i);
        for (int i = 0; i < NI; i++) advance(i);
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic clr(input int i);
        rises[i] = 0; cs_low[i] = 0; rxv_cnt[i] = 0;
        mosi_ones[i] = 0; mosi_cap[i] = '0;
    endtask

    task automatic pulse0(input logic [F-1:0] w);
        tx[0] = w;
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
    endtask

    logic [F-1:0] words [3];

    initial begin
        for (int i = 0; i < NI; i++) begin
            busy[i] = 1'b0; off[i] = 0; rxd_e[i] = '0;
            txm[i] = '0; rxe[i] = '0;
            prev_sclk[i] = 1'b0; prev_cs[i] = 1'b1;
            hi_run[i] = 0; fr_rises[i] = 0;
            clr(i);
        end
        rst = '1; start = '0; tx = '0;
        @(posedge clk);
        #1;
        run(2);
        rst = '0;
        run(5);

        // Reset in idle
        rst[0] = 1'b1;
        run(3);
        chk("reset_cs", 64'(cs[0]), 64'd1);
        chk("reset_sclk_mosi", 64'({sclk[0], mosi[0]}), 64'd0);
        chk("reset_ready", 64'(ready[0]), 64'd1);
        chk("reset_rx", 64'({rxv[0], rxd[0]}), 64'd0);
        rst[0] = 1'b0;
        run(2);

        // Loopback frame
        clr(0);
        pulse0(32'hA5A50F0F);
        run(140);
        chk("loop_rx", 64'(rxd[0]), 64'hA5A50F0F);
        chk("loop_rises", 64'(rises[0]), 64'd32);
        chk("loop_cs_low", 64'(cs_low[0]), 64'd130);
        chk("loop_rxv_cnt", 64'(rxv_cnt[0]), 64'd1);

        // Slave returning a fixed word
        slv_mode = 1'b1;
        clr(0);
        pulse0(32'hDEADBEEF);
        run(140);
        chk("slave_rx", 64'(rxd[0]), 64'h12345678);
        chk("slave_mosi", 64'(mosi_cap[0]), 64'hDEADBEEF);
        chk("slave_rxv_cnt", 64'(rxv_cnt[0]), 64'd1);
        slv_mode = 1'b0;

        // Start while busy is ignored
        clr(0);
        pulse0(32'h0);
        run(39);
        pulse0(32'hFFFFFFFF);
        run(120);
        chk("busy_rxv_cnt", 64'(rxv_cnt[0]), 64'd1);
        chk("busy_mosi_ones", 64'(mosi_ones[0]), 64'd0);
        chk("busy_rises", 64'(rises[0]), 64'd32);
        chk("busy_rx", 64'(rxd[0]), 64'd0);

        // Abort by reset mid-frame, then a clean frame
        clr(0);
        pulse0(32'h5A5A_F00F);
        run(59);
        rst[0] = 1'b1;
        tick();
        rst[0] = 1'b0;
        tick();
        chk("abort_cs", 64'(cs[0]), 64'd1);
        chk("abort_rx", 64'(rxd[0]), 64'd0);
        run(10);
        chk("abort_no_rxv", 64'(rxv_cnt[0]), 64'd0);
        clr(0);
        pulse0(32'h3C5A9671);
        run(140);
        chk("after_abort_rx", 64'(rxd[0]), 64'h3C5A9671);
        chk("after_abort_rises", 64'(rises[0]), 64'd32);
        chk("after_abort_cs_low", 64'(cs_low[0]), 64'd130);

        // Back-to-back with minimum timing on the second instance
        gap_q.delete(); rise_q.delete(); rx1_q.delete();
        seen1 = 1'b0;
        for (int k = 0; k < 3; k++) words[k] = $urandom;
        start[1] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            int n;
            tx[1] = words[k];
            n = 0;
            do begin
                tick();
                n++;
            end while (!(busy[1] && off[1] == 0) && n < 200);
            chk("b2b_accept_timeout", 64'(n < 200), 64'd1);
        end
        start[1] = 1'b0;
        tx[1] = '0;
        run(80);
        chk("b2b_gap_count", 64'(gap_q.size()), 64'd2);
        foreach (gap_q[k]) chk("b2b_gap_len", 64'(gap_q[k]), 64'd2);
        chk("b2b_frame_count", 64'(rise_q.size()), 64'd3);
        foreach (rise_q[k]) chk("b2b_rises", 64'(rise_q[k]), 64'd32);
        chk("b2b_rx_count", 64'(rx1_q.size()), 64'd3);
        foreach (rx1_q[k]) begin
            if (k < 3) chk("b2b_rx", 64'(rx1_q[k]), 64'(words[k]));
        end

        // Random traffic on both instances
        for (int blk = 0; blk < 6; blk++) begin
            slv_mode = blk[0];
            repeat (400) begin
                for (int i = 0; i < NI; i++) begin
                    start[i] = ($urandom_range(0, 7) == 0);
                    tx[i]    = $urandom;
                    rst[i]   = ($urandom_range(0, 599) == 0);
                end
                tick();
            end
            start = '0;
            rst = '0;
            run(150);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
